rcservo_capture: RTL and testbench



---
 rtl/rcservo_capture_if.sv | 28 ++
 rtl/rcservo_capture.sv | 166 ++++++++++++++++
 tb/tb_rcservo_capture.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rcservo_capture_if.sv
// Secondary register bus: address, strobes and write data from the primary block,
// read data returned to the top-level mux.
interface rcservo_capture_if;
  logic [4:0]  Addr;
  logic [15:0] DataWr;
  logic [15:0] DataRd;
  logic        En;
  logic        Rd;
  logic        Wr;

  modport master (
    output Addr,
    output DataWr,
    output En,
    output Rd,
    output Wr,
    input  DataRd
  );

  modport slave (
    input  Addr,
    input  DataWr,
    input  En,
    input  Rd,
    input  Wr,
    output DataRd
  );
endinterface

// File: rtl/rcservo_capture.sv
// Multi-channel RC pulse-width decoder: measures each channel's high time in prescaled ticks,
// validates it against MIN_W..MAX_W and reports new-sample and signal-loss flags.
module rcservo_capture #(
  parameter int unsigned N          = 8,
  parameter int unsigned DIV        = 16,
  parameter int unsigned MIN_W      = 500,
  parameter int unsigned MAX_W      = 2500,
  parameter int unsigned LOST_TICKS = 50000
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [N-1:0]     P,
  rcservo_capture_if.slave bus
);

  localparam int unsigned DivW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [4:0]  AddrNew  = 5'd16;
  localparam logic [4:0]  AddrLost = 5'd17;
  localparam logic [4:0]  AddrCtrl = 5'd24;
  localparam logic [15:0] SatCnt   = 16'hFFFF;
  localparam logic [15:0] MinCnt   = 16'(MIN_W);
  localparam logic [15:0] MaxCnt   = 16'(MAX_W);
  localparam logic [15:0] LostCnt  = 16'(LOST_TICKS);

  // Prescaler
  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == DivW'(DIV - 1));

  // Input synchronizers and edge detection
  logic [N-1:0] sync1_q, sync2_q, prev_q;
  logic [N-1:0] rise, fall;

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Control and per-channel state
  logic         enable_q, enable_d;
  logic [N-1:0] armed_q, armed_d;
  logic [N-1:0] new_q, new_d;
  logic [N-1:0] lost_q, lost_d;
  logic [15:0]  high_q [N];
  logic [15:0]  high_d [N];
  logic [15:0]  idle_q [N];
  logic [15:0]  idle_d [N];
  logic [15:0]  width_q [N];
  logic [15:0]  width_d [N];
  logic [N-1:0] capture;
  logic [N-1:0] lost_hit;
  logic [N-1:0] clear_new;

  logic wr_ctrl, wr_new;
  logic unused_datawr;

  assign wr_ctrl       = bus.En & bus.Wr & (bus.Addr == AddrCtrl);
  assign wr_new        = bus.En & bus.Wr & (bus.Addr == AddrNew);
  assign enable_d      = wr_ctrl ? bus.DataWr[0] : enable_q;
  assign unused_datawr = ^bus.DataWr;

  always_comb begin
    clear_new = '0;
    for (int unsigned ch = 0; ch < N; ch++) begin
      clear_new[ch] = (bus.En & bus.Rd & (bus.Addr == 5'(ch))) | (wr_new & bus.DataWr[ch]);
    end
  end

  always_comb begin
    armed_d  = armed_q;
    new_d    = new_q;
    lost_d   = lost_q;
    capture  = '0;
    lost_hit = '0;
    for (int unsigned ch = 0; ch < N; ch++) begin
      high_d[ch]  = high_q[ch];
      idle_d[ch]  = idle_q[ch];
      width_d[ch] = width_q[ch];

      if (!enable_q) begin
        high_d[ch]  = '0;
        idle_d[ch]  = '0;
        armed_d[ch] = 1'b0;
      end else begin
        // A pulse is only measured once its rising edge has been seen while enabled.
        if (rise[ch]) begin
          armed_d[ch] = 1'b1;
          high_d[ch]  = {15'd0, tick};
        end else if (armed_q[ch] && sync2_q[ch] && tick && (high_q[ch] != SatCnt)) begin
          high_d[ch] = high_q[ch] + 16'd1;
        end

        if (fall[ch]) begin
          armed_d[ch] = 1'b0;
          capture[ch] = armed_q[ch] && (high_q[ch] >= MinCnt) && (high_q[ch] <= MaxCnt);
        end

        if (capture[ch]) begin
          idle_d[ch] = '0;
        end else if (tick && (idle_q[ch] != LostCnt)) begin
          idle_d[ch]   = idle_q[ch] + 16'd1;
          lost_hit[ch] = (idle_q[ch] == (LostCnt - 16'd1));
        end
      end

      // Capture takes priority over any same-cycle read or write-1-to-clear.
      if (capture[ch]) begin
        width_d[ch] = high_q[ch];
        new_d[ch]   = 1'b1;
        lost_d[ch]  = 1'b0;
      end else if (lost_hit[ch]) begin
        width_d[ch] = '0;
        new_d[ch]   = 1'b0;
        lost_d[ch]  = 1'b1;
      end else if (clear_new[ch]) begin
        new_d[ch] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      div_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      enable_q <= 1'b1;
      armed_q  <= '0;
      new_q    <= '0;
      lost_q   <= '1;
      for (int unsigned ch = 0; ch < N; ch++) begin
        high_q[ch]  <= '0;
        idle_q[ch]  <= '0;
        width_q[ch] <= '0;
      end
    end else begin
      div_q    <= tick ? '0 : div_q + DivW'(1);
      sync1_q  <= P;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      enable_q <= enable_d;
      armed_q  <= armed_d;
      new_q    <= new_d;
      lost_q   <= lost_d;
      for (int unsigned ch = 0; ch < N; ch++) begin
        high_q[ch]  <= high_d[ch];
        idle_q[ch]  <= idle_d[ch];
        width_q[ch] <= width_d[ch];
      end
    end
  end

  always_comb begin
    bus.DataRd = '0;
    case (bus.Addr)
      AddrNew:  bus.DataRd = 16'(new_q);
      AddrLost: bus.DataRd = 16'(lost_q);
      AddrCtrl: bus.DataRd = {15'd0, enable_q};
      default: begin
        for (int unsigned ch = 0; ch < N; ch++) begin
          if (bus.Addr == 5'(ch)) bus.DataRd = width_q[ch];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rcservo_capture.sv
// Bench for rcservo_capture: a DIV=4 instance and a DIV=1 instance checked against a
// pulse-level reference model of accepted widths and flags.
module tb_rcservo_capture;
  localparam int unsigned DivA   = 4;
  localparam int unsigned DivB   = 1;
  localparam int unsigned MinW   = 500;
  localparam int unsigned MaxW   = 2500;
  localparam int unsigned LostT  = 50000;
  localparam int unsigned SatLen = 65536 + 1500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pa;
  logic [6:0] pb;
  logic       sat_p;
  logic [7:0] p_b;
  bit         sat_done;

  int checks = 0;
  int errors = 0;

  // Reference model state for instance B
  int         exp_w_b [8];
  logic [7:0] exp_new_b;
  logic [7:0] exp_lost_b;

  always #5 clk = ~clk;

  assign p_b = {sat_p, pb};

  rcservo_capture_if ifa ();
  rcservo_capture_if ifb ();

  rcservo_capture #(
    .N(8), .DIV(DivA), .MIN_W(MinW), .MAX_W(MaxW), .LOST_TICKS(LostT)
  ) u_dut_a (
    .Clk(clk), .ResetN(rst_n), .P(pa), .bus(ifa)
  );

  rcservo_capture #(
    .N(8), .DIV(DivB), .MIN_W(MinW), .MAX_W(MaxW), .LOST_TICKS(LostT)
  ) u_dut_b (
    .Clk(clk), .ResetN(rst_n), .P(p_b), .bus(ifb)
  );

  function automatic void model_pulse_b(input int ch, input int len);
    int cnt;
    cnt = (len > 65535) ? 65535 : len;
    if (cnt >= int'(MinW) && cnt <= int'(MaxW)) begin
      exp_w_b[ch]    = cnt;
      exp_new_b[ch]  = 1'b1;
      exp_lost_b[ch] = 1'b0;
    end
  endfunction

  function automatic void model_loss_b(input int ch);
    exp_w_b[ch]    = 0;
    exp_new_b[ch]  = 1'b0;
    exp_lost_b[ch] = 1'b1;
  endfunction

  task automatic read_reg(input int inst, input logic [4:0] addr, input bit strobe,
                          output logic [15:0] data);
    @(negedge clk);
    if (inst == 0) begin
      ifa.Addr = addr; ifa.En = 1'b1; ifa.Rd = strobe;
      #1 data = ifa.DataRd;
    end else begin
      ifb.Addr = addr; ifb.En = 1'b1; ifb.Rd = strobe;
      #1 data = ifb.DataRd;
    end
    @(negedge clk);
    if (inst == 0) begin ifa.En = 1'b0; ifa.Rd = 1'b0; end
    else begin ifb.En = 1'b0; ifb.Rd = 1'b0; end
  endtask

  task automatic write_reg(input int inst, input logic [4:0] addr, input logic [15:0] data);
    @(negedge clk);
    if (inst == 0) begin
      ifa.Addr = addr; ifa.DataWr = data; ifa.En = 1'b1; ifa.Wr = 1'b1;
    end else begin
      ifb.Addr = addr; ifb.DataWr = data; ifb.En = 1'b1; ifb.Wr = 1'b1;
    end
    @(negedge clk);
    if (inst == 0) begin ifa.En = 1'b0; ifa.Wr = 1'b0; end
    else begin ifb.En = 1'b0; ifb.Wr = 1'b0; end
  endtask

  task automatic pulse_a(input logic [2:0] ch, input int len);
    @(negedge clk);
    pa[ch] = 1'b1;
    repeat (len) @(negedge clk);
    pa[ch] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_b(input logic [2:0] ch, input int len);
    @(negedge clk);
    pb[ch] = 1'b1;
    repeat (len) @(negedge clk);
    pb[ch] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int inst = 0; inst < 2; inst++) begin
      read_reg(inst, 5'd17, 1'b0, d);
      checks++;
      if (d !== 16'h00FF) begin
        errors++; $display("FAIL reset_lost inst=%0d got %h expected 00ff", inst, d);
      end
      read_reg(inst, 5'd16, 1'b0, d);
      checks++;
      if (d !== 16'h0000) begin
        errors++; $display("FAIL reset_new inst=%0d got %h expected 0000", inst, d);
      end
      read_reg(inst, 5'd0, 1'b0, d);
      checks++;
      if (d !== 16'h0000) begin
        errors++; $display("FAIL reset_width0 inst=%0d got %h expected 0000", inst, d);
      end
      read_reg(inst, 5'd24, 1'b0, d);
      checks++;
      if (d !== 16'h0001) begin
        errors++; $display("FAIL reset_ctrl inst=%0d got %h expected 0001", inst, d);
      end
    end
  endtask

  task automatic start_saturation();
    fork
      begin
        @(negedge clk);
        sat_p = 1'b1;
        repeat (SatLen) @(negedge clk);
        sat_p    = 1'b0;
        sat_done = 1'b1;
      end
    join_none
  endtask

  task automatic test_limits();
    int          lens [6];
    logic [15:0] d;
    lens = '{499, 500, 2500, 2501, 0, 0};
    lens[4] = int'($urandom_range(450, 2550));
    lens[5] = int'($urandom_range(450, 2550));
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        read_reg(1, 5'd2, 1'b1, d);
        exp_new_b[2] = 1'b0;
      end
      pulse_b(3'd2, lens[i]);
      model_pulse_b(2, lens[i]);
      read_reg(1, 5'd2, 1'b0, d);
      checks++;
      if (d !== 16'(exp_w_b[2])) begin
        errors++; $display("FAIL limits_width len=%0d got %0d expected %0d", lens[i], d, exp_w_b[2]);
      end
      read_reg(1, 5'd16, 1'b0, d);
      checks++;
      if (d[2] !== exp_new_b[2]) begin
        errors++; $display("FAIL limits_new len=%0d got %b expected %b", lens[i], d[2], exp_new_b[2]);
      end
      read_reg(1, 5'd17, 1'b0, d);
      checks++;
      if (d[2] !== exp_lost_b[2]) begin
        errors++;
        $display("FAIL limits_lost len=%0d got %b expected %b", lens[i], d[2], exp_lost_b[2]);
      end
    end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    pulse_b(3'd3, 1000);
    model_pulse_b(3, 1000);
    read_reg(1, 5'd3, 1'b1, d);
    exp_new_b[3] = 1'b0;
    checks++;
    if (d !== 16'(exp_w_b[3])) begin
      errors++; $display("FAIL coll_first_width got %0d expected %0d", d, exp_w_b[3]);
    end
    read_reg(1, 5'd16, 1'b0, d);
    checks++;
    if (d[3] !== exp_new_b[3]) begin
      errors++; $display("FAIL coll_new_cleared got %b expected %b", d[3], exp_new_b[3]);
    end
    // Fall at n0 reaches the capture edge after the third following posedge.
    @(negedge clk);
    pb[3] = 1'b1;
    repeat (1200) @(negedge clk);
    pb[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ifb.Addr = 5'd3; ifb.En = 1'b1; ifb.Rd = 1'b1;
    #1 d = ifb.DataRd;
    checks++;
    if (d !== 16'(exp_w_b[3])) begin
      errors++; $display("FAIL coll_read_old got %0d expected %0d", d, exp_w_b[3]);
    end
    @(negedge clk);
    ifb.En = 1'b0; ifb.Rd = 1'b0;
    model_pulse_b(3, 1200);
    read_reg(1, 5'd3, 1'b0, d);
    checks++;
    if (d !== 16'(exp_w_b[3])) begin
      errors++; $display("FAIL coll_width_new got %0d expected %0d", d, exp_w_b[3]);
    end
    read_reg(1, 5'd16, 1'b0, d);
    checks++;
    if (d[3] !== exp_new_b[3]) begin
      errors++; $display("FAIL coll_new_kept got %b expected %b", d[3], exp_new_b[3]);
    end
  endtask

  task automatic test_loss();
    logic [15:0] d;
    bit          found;
    bit          lost_seen;
    int          cnt;
    @(negedge clk);
    pb[0] = 1'b1;
    repeat (1500) @(negedge clk);
    pb[0] = 1'b0;
    ifb.Addr = 5'd16;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifb.DataRd[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL loss_capture got none expected new bit0 within 10 cycles");
    end
    model_pulse_b(0, 1500);
    ifb.Addr  = 5'd17;
    cnt       = 0;
    lost_seen = 1'b0;
    while (!lost_seen && cnt < 60000) begin
      @(negedge clk);
      cnt++;
      if (ifb.DataRd[0] === 1'b1) lost_seen = 1'b1;
    end
    checks++;
    if (!lost_seen || cnt != int'(LostT * DivB)) begin
      errors++;
      $display("FAIL loss_timing got %0d cycles (seen=%0d) expected %0d", cnt, lost_seen, LostT * DivB);
    end
    model_loss_b(0);
    read_reg(1, 5'd0, 1'b0, d);
    checks++;
    if (d !== 16'(exp_w_b[0])) begin
      errors++; $display("FAIL loss_width got %0d expected %0d", d, exp_w_b[0]);
    end
    read_reg(1, 5'd16, 1'b0, d);
    checks++;
    if (d[0] !== exp_new_b[0]) begin
      errors++; $display("FAIL loss_new got %b expected %b", d[0], exp_new_b[0]);
    end
    pulse_b(3'd0, 1500);
    model_pulse_b(0, 1500);
    read_reg(1, 5'd17, 1'b0, d);
    checks++;
    if (d[0] !== exp_lost_b[0]) begin
      errors++; $display("FAIL loss_recover got %b expected %b", d[0], exp_lost_b[0]);
    end
    read_reg(1, 5'd0, 1'b0, d);
    checks++;
    if (d !== 16'(exp_w_b[0])) begin
      errors++; $display("FAIL loss_recover_width got %0d expected %0d", d, exp_w_b[0]);
    end
  endtask

  task automatic test_nominal();
    logic [15:0] d;
    int          len;
    int          exp_ticks;
    int          diff;
    exp_ticks = 6000 / int'(DivA);
    pulse_a(3'd0, 6000);
    read_reg(0, 5'd0, 1'b0, d);
    diff = int'(d) - exp_ticks;
    checks++;
    if (diff > 1 || diff < -1) begin
      errors++; $display("FAIL nominal_width got %0d expected %0d+-1", d, exp_ticks);
    end
    read_reg(0, 5'd16, 1'b0, d);
    checks++;
    if (d[0] !== 1'b1) begin
      errors++; $display("FAIL nominal_new got %b expected 1", d[0]);
    end
    read_reg(0, 5'd17, 1'b0, d);
    checks++;
    if (d[0] !== 1'b0) begin
      errors++; $display("FAIL nominal_lost got %b expected 0", d[0]);
    end
    read_reg(0, 5'd0, 1'b1, d);
    read_reg(0, 5'd16, 1'b0, d);
    checks++;
    if (d[0] !== 1'b0) begin
      errors++; $display("FAIL nominal_read_clear got %b expected 0", d[0]);
    end
    len       = int'($urandom_range(2400, 4000));
    exp_ticks = len / int'(DivA);
    pulse_a(3'd5, len);
    read_reg(0, 5'd5, 1'b1, d);
    diff = int'(d) - exp_ticks;
    checks++;
    if (diff > 1 || diff < -1) begin
      errors++; $display("FAIL nominal_rand_width len=%0d got %0d expected %0d+-1", len, d, exp_ticks);
    end
  endtask

  task automatic test_w1c();
    logic [15:0] d;
    int          l0, l2, lmax;
    int          diff;
    l0   = int'($urandom_range(2400, 4000));
    l2   = int'($urandom_range(2400, 4000));
    lmax = (l0 > l2) ? l0 : l2;
    @(negedge clk);
    pa[0] = 1'b1;
    pa[2] = 1'b1;
    for (int i = 1; i <= lmax; i++) begin
      @(negedge clk);
      if (i == l0) pa[0] = 1'b0;
      if (i == l2) pa[2] = 1'b0;
    end
    repeat (8) @(negedge clk);
    read_reg(0, 5'd16, 1'b0, d);
    checks++;
    if (d !== 16'h0005) begin
      errors++; $display("FAIL w1c_before got %h expected 0005", d);
    end
    write_reg(0, 5'd16, 16'h0001);
    read_reg(0, 5'd16, 1'b0, d);
    checks++;
    if (d !== 16'h0004) begin
      errors++; $display("FAIL w1c_after got %h expected 0004", d);
    end
    read_reg(0, 5'd2, 1'b0, d);
    diff = int'(d) - l2 / int'(DivA);
    checks++;
    if (diff > 1 || diff < -1) begin
      errors++; $display("FAIL w1c_width2 got %0d expected %0d+-1", d, l2 / int'(DivA));
    end
  endtask

  task automatic test_saturation();
    logic [15:0] d;
    for (int i = 0; i < 80000 && !sat_done; i++) @(negedge clk);
    checks++;
    if (!sat_done) begin
      errors++; $display("FAIL sat_timeout got no pulse end expected within budget");
    end
    repeat (8) @(negedge clk);
    // Channel 7 idles past the loss limit while the long pulse is high.
    model_loss_b(7);
    model_pulse_b(7, int'(SatLen));
    read_reg(1, 5'd7, 1'b0, d);
    checks++;
    if (d !== 16'(exp_w_b[7])) begin
      errors++; $display("FAIL sat_width got %0d expected %0d", d, exp_w_b[7]);
    end
    read_reg(1, 5'd16, 1'b0, d);
    checks++;
    if (d[7] !== exp_new_b[7]) begin
      errors++; $display("FAIL sat_new got %b expected %b", d[7], exp_new_b[7]);
    end
    read_reg(1, 5'd17, 1'b0, d);
    checks++;
    if (d[7] !== exp_lost_b[7]) begin
      errors++; $display("FAIL sat_lost got %b expected %b", d[7], exp_lost_b[7]);
    end
  endtask

  task automatic test_enable();
    logic [15:0] d;
    @(negedge clk);
    pb[1] = 1'b1;
    repeat (300) @(negedge clk);
    write_reg(1, 5'd24, 16'h0000);
    read_reg(1, 5'd24, 1'b0, d);
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL en_ctrl_off got %h expected 0000", d);
    end
    repeat (100) @(negedge clk);
    write_reg(1, 5'd24, 16'hFFFF);
    repeat (100) @(negedge clk);
    pb[1] = 1'b0;
    repeat (8) @(negedge clk);
    read_reg(1, 5'd24, 1'b0, d);
    checks++;
    if (d !== 16'h0001) begin
      errors++; $display("FAIL en_ctrl_on got %h expected 0001", d);
    end
    read_reg(1, 5'd16, 1'b0, d);
    checks++;
    if (d[1] !== exp_new_b[1]) begin
      errors++; $display("FAIL en_no_capture_new got %b expected %b", d[1], exp_new_b[1]);
    end
    read_reg(1, 5'd1, 1'b0, d);
    checks++;
    if (d !== 16'(exp_w_b[1])) begin
      errors++; $display("FAIL en_no_capture_width got %0d expected %0d", d, exp_w_b[1]);
    end
    pulse_b(3'd1, 1000);
    model_pulse_b(1, 1000);
    read_reg(1, 5'd1, 1'b0, d);
    checks++;
    if (d !== 16'(exp_w_b[1])) begin
      errors++; $display("FAIL en_next_width got %0d expected %0d", d, exp_w_b[1]);
    end
    read_reg(1, 5'd16, 1'b0, d);
    checks++;
    if (d[1] !== exp_new_b[1]) begin
      errors++; $display("FAIL en_next_new got %b expected %b", d[1], exp_new_b[1]);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pa         = '0;
    pb         = '0;
    sat_p      = 1'b0;
    sat_done   = 1'b0;
    exp_new_b  = '0;
    exp_lost_b = '1;
    for (int i = 0; i < 8; i++) exp_w_b[i] = 0;
    ifa.Addr = '0; ifa.DataWr = '0; ifa.En = 1'b0; ifa.Rd = 1'b0; ifa.Wr = 1'b0;
    ifb.Addr = '0; ifb.DataWr = '0; ifb.En = 1'b0; ifb.Rd = 1'b0; ifb.Wr = 1'b0;

    test_reset();
    start_saturation();
    test_limits();
    test_collision();
    fork
      test_loss();
      begin
        test_nominal();
        test_w1c();
      end
    join
    test_saturation();
    test_enable();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
